// File: rtl/vid_timing_gen.sv
// Video raster timing and test-pattern source.
// Counter stage picks the raster position; output stage registers sync, DE and pixels.
module vid_timing_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_en,
    input  logic [CNT_WIDTH-1:0]    i_hsw,
    input  logic [CNT_WIDTH-1:0]    i_hbp,
    input  logic [CNT_WIDTH-1:0]    i_hact,
    input  logic [CNT_WIDTH-1:0]    i_hfp,
    input  logic [CNT_WIDTH-1:0]    i_vsw,
    input  logic [CNT_WIDTH-1:0]    i_vbp,
    input  logic [CNT_WIDTH-1:0]    i_vact,
    input  logic [CNT_WIDTH-1:0]    i_vfp,
    input  logic [1:0]              i_pat_sel,
    input  logic [3*DATA_WIDTH-1:0] i_solid,
    output logic                    o_vs,
    output logic                    o_hs,
    output logic                    o_de,
    output logic [DATA_WIDTH-1:0]   o_r,
    output logic [DATA_WIDTH-1:0]   o_g,
    output logic [DATA_WIDTH-1:0]   o_b,
    output logic                    o_busy,
    output logic                    o_frame_done
);

    localparam int SW = CNT_WIDTH + 2;
    typedef logic [SW-1:0] sum_t;
    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;
    logic   load;
    logic   frame_last;

    logic [CNT_WIDTH-1:0]    h_q, v_q;
    logic [CNT_WIDTH-1:0]    hsw_q, hbp_q, hact_q, hfp_q;
    logic [CNT_WIDTH-1:0]    vsw_q, vbp_q, vact_q, vfp_q;
    logic [1:0]              pat_q;
    logic [3*DATA_WIDTH-1:0] solid_q;

    sum_t h_ext, v_ext;
    sum_t hde_beg, hde_end, ht;
    sum_t vde_beg, vde_end, vt;
    logic h_last, v_last;
    logic de_nxt;
    logic [DATA_WIDTH-1:0] x, y;
    logic [DATA_WIDTH-1:0] pr, pg, pb;

    assign h_ext   = sum_t'(h_q);
    assign v_ext   = sum_t'(v_q);
    assign hde_beg = sum_t'(hsw_q) + sum_t'(hbp_q);
    assign hde_end = hde_beg + sum_t'(hact_q);
    assign ht      = hde_end + sum_t'(hfp_q);
    assign vde_beg = sum_t'(vsw_q) + sum_t'(vbp_q);
    assign vde_end = vde_beg + sum_t'(vact_q);
    assign vt      = vde_end + sum_t'(vfp_q);

    assign h_last     = (h_ext == ht - sum_t'(1));
    assign v_last     = (v_ext == vt - sum_t'(1));
    assign frame_last = h_last && v_last;

    assign de_nxt = (v_ext >= vde_beg) && (v_ext < vde_end) &&
                    (h_ext >= hde_beg) && (h_ext < hde_end);
    assign x = DATA_WIDTH'(h_ext - hde_beg);
    assign y = DATA_WIDTH'(v_ext - vde_beg);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (i_en) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                // stop/continue is decided only at the frame boundary
                if (frame_last) begin
                    if (i_en) load = 1'b1;
                    else      state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_q <= '0;
            v_q <= '0;
        end else if (load) begin
            h_q <= '0;
            v_q <= '0;
        end else if (state == RUN) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + CNT_WIDTH'(1);
            end else begin
                h_q <= h_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsw_q   <= CNT_WIDTH'(1);
            hbp_q   <= '0;
            hact_q  <= '0;
            hfp_q   <= '0;
            vsw_q   <= CNT_WIDTH'(1);
            vbp_q   <= '0;
            vact_q  <= '0;
            vfp_q   <= '0;
            pat_q   <= '0;
            solid_q <= '0;
        end else if (load) begin
            // zero-width syncs are widened to one pixel/line
            hsw_q   <= (i_hsw == '0) ? CNT_WIDTH'(1) : i_hsw;
            hbp_q   <= i_hbp;
            hact_q  <= i_hact;
            hfp_q   <= i_hfp;
            vsw_q   <= (i_vsw == '0) ? CNT_WIDTH'(1) : i_vsw;
            vbp_q   <= i_vbp;
            vact_q  <= i_vact;
            vfp_q   <= i_vfp;
            pat_q   <= i_pat_sel;
            solid_q <= i_solid;
        end
    end

    always_comb begin
        pr = '0;
        pg = '0;
        pb = '0;
        if (de_nxt) begin
            case (pat_q)
                2'd0: begin
                    pr = x;
                    pg = x;
                    pb = x;
                end
                2'd1: begin
                    pr = y;
                    pg = y;
                    pb = y;
                end
                2'd2: begin
                    pr = solid_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
                    pg = solid_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    pb = solid_q[DATA_WIDTH-1:0];
                end
                default: begin
                    pr = {DATA_WIDTH{x[3] ^ y[3]}};
                    pg = {DATA_WIDTH{x[3] ^ y[3]}};
                    pb = {DATA_WIDTH{x[3] ^ y[3]}};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vs         <= 1'b0;
            o_hs         <= 1'b0;
            o_de         <= 1'b0;
            o_r          <= '0;
            o_g          <= '0;
            o_b          <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else if (state == RUN) begin
            o_vs         <= (v_ext < sum_t'(vsw_q));
            o_hs         <= (h_ext < sum_t'(hsw_q));
            o_de         <= de_nxt;
            o_r          <= pr;
            o_g          <= pg;
            o_b          <= pb;
            o_busy       <= 1'b1;
            o_frame_done <= frame_last;
        end else begin
            o_vs         <= 1'b0;
            o_hs         <= 1'b0;
            o_de         <= 1'b0;
            o_r          <= '0;
            o_g          <= '0;
            o_b          <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Scoreboard bench for vid_timing_gen.
// Stimulus queues the expected raster; a negedge monitor pops and compares.
module tb_vid_timing_gen;

    localparam int DW = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_en = 1'b0;
    logic [CW-1:0] i_hsw, i_hbp, i_hact, i_hfp;
    logic [CW-1:0] i_vsw, i_vbp, i_vact, i_vfp;
    logic [1:0]    i_pat_sel;
    logic [23:0]   i_solid;
    logic          o_vs, o_hs, o_de, o_busy, o_frame_done;
    logic [DW-1:0] o_r, o_g, o_b;

    typedef struct {
        int hsw, hbp, hact, hfp;
        int vsw, vbp, vact, vfp;
        int pat;
        logic [23:0] solid;
    } cfg_t;

    typedef struct packed {
        logic vs, hs, de;
        logic [7:0] r, g, b;
        logic done;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int busy_cnt, de_cnt, done_cnt, vs_rise, hs_cnt, vs_cnt;
    int first_de, seg_cnt, solid_cnt;
    logic vs_prev = 1'b0;
    logic busy_prev = 1'b0;

    vid_timing_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en),
        .i_hsw(i_hsw), .i_hbp(i_hbp), .i_hact(i_hact), .i_hfp(i_hfp),
        .i_vsw(i_vsw), .i_vbp(i_vbp), .i_vact(i_vact), .i_vfp(i_vfp),
        .i_pat_sel(i_pat_sel), .i_solid(i_solid),
        .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    function automatic int hwid(cfg_t c);
        return ((c.hsw == 0) ? 1 : c.hsw) + c.hbp + c.hact + c.hfp;
    endfunction

    function automatic int vhgt(cfg_t c);
        return ((c.vsw == 0) ? 1 : c.vsw) + c.vbp + c.vact + c.vfp;
    endfunction

    function automatic exp_t model(cfg_t c, int h, int v);
        exp_t e;
        int hs_w, vs_w, hb, vb, x, y;
        logic [7:0] p;
        e = '0;
        hs_w = (c.hsw == 0) ? 1 : c.hsw;
        vs_w = (c.vsw == 0) ? 1 : c.vsw;
        hb = hs_w + c.hbp;
        vb = vs_w + c.vbp;
        x = h - hb;
        y = v - vb;
        e.hs = (h < hs_w);
        e.vs = (v < vs_w);
        e.done = (h == hwid(c) - 1) && (v == vhgt(c) - 1);
        e.de = (v >= vb) && (v < vb + c.vact) && (h >= hb) && (h < hb + c.hact);
        if (e.de) begin
            case (c.pat)
                0: begin p = x[7:0]; e.r = p; e.g = p; e.b = p; end
                1: begin p = y[7:0]; e.r = p; e.g = p; e.b = p; end
                2: begin e.r = c.solid[23:16]; e.g = c.solid[15:8]; e.b = c.solid[7:0]; end
                default: begin
                    p = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
                    e.r = p; e.g = p; e.b = p;
                end
            endcase
        end
        return e;
    endfunction

    task automatic push_frame(input cfg_t c);
        for (int v = 0; v < vhgt(c); v++)
            for (int h = 0; h < hwid(c); h++)
                q.push_back(model(c, h, v));
    endtask

    task automatic apply_cfg(input cfg_t c);
        i_hsw = CW'(c.hsw);  i_hbp = CW'(c.hbp);
        i_hact = CW'(c.hact); i_hfp = CW'(c.hfp);
        i_vsw = CW'(c.vsw);  i_vbp = CW'(c.vbp);
        i_vact = CW'(c.vact); i_vfp = CW'(c.vfp);
        i_pat_sel = 2'(c.pat);
        i_solid = c.solid;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic clr_stats();
        busy_cnt = 0; de_cnt = 0; done_cnt = 0; vs_rise = 0;
        hs_cnt = 0; vs_cnt = 0; first_de = -1; seg_cnt = 0; solid_cnt = 0;
    endtask

    // Hold i_en for exactly T raster cycles worth of boundaries.
    task automatic run(input int t);
        i_en = 1'b1;
        @(posedge clk); #1;
        chk("lat_n", int'(o_busy), 0);
        @(posedge clk); #1;
        chk("lat_n1", int'({o_busy, o_vs, o_hs}), 7);
        repeat (t - 2) @(posedge clk);
        #1 i_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((o_busy || q.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, int'(n >= 3000), 0);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_qleft"}, q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        g = {o_vs, o_hs, o_de, o_r, o_g, o_b, o_frame_done};
        if (o_busy) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_cycle got=%h exp=none", g);
            end else begin
                e = q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL pixel n=%0d got=%h exp=%h", busy_cnt, g, e);
                end
            end
            if (!busy_prev) seg_cnt++;
            if (o_de && first_de < 0) first_de = busy_cnt;
            if (o_de) de_cnt++;
            if (o_de && {o_r, o_g, o_b} == 24'h123456) solid_cnt++;
            if (o_frame_done) done_cnt++;
            if (o_vs && !vs_prev) vs_rise++;
            if (o_hs) hs_cnt++;
            if (o_vs) vs_cnt++;
            busy_cnt++;
        end else begin
            total++;
            if (g !== '0) begin
                bad++;
                $display("FAIL idle_out got=%h exp=0", g);
            end
        end
        vs_prev = o_vs;
        busy_prev = o_busy;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        cfg_t g, g2, gz, gs, gc;
        g  = '{1, 3, 8, 3, 1, 3, 4, 3, 0, 24'h0};
        g2 = g; g2.hact = 16; g2.pat = 1;
        gz = g; gz.hsw = 0; gz.vsw = 0; gz.vact = 0;
        gs = g; gs.pat = 2; gs.solid = 24'h123456;
        gc = g; gc.hact = 16; gc.pat = 3;
        clr_stats();
        apply_cfg(g);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("reset_out", int'({o_vs, o_hs, o_de, o_busy, o_frame_done, o_r, o_g, o_b}), 0);

        clr_stats();
        push_frame(g);
        i_en = 1'b1;
        @(posedge clk); #1;
        i_en = 1'b0;
        chk("geo_lat_n", int'(o_busy), 0);
        @(posedge clk); #1;
        chk("geo_lat_n1", int'({o_busy, o_vs, o_hs}), 7);
        wait_idle("geo");
        chk("geo_len", busy_cnt, 165);
        chk("geo_de", de_cnt, 32);
        chk("geo_first_de", first_de, 64);
        chk("geo_done", done_cnt, 1);

        clr_stats();
        repeat (3) push_frame(g);
        run(495);
        wait_idle("cont");
        chk("cont_len", busy_cnt, 495);
        chk("cont_seg", seg_cnt, 1);
        chk("cont_vs_rise", vs_rise, 3);
        chk("cont_done", done_cnt, 3);

        clr_stats();
        push_frame(g);
        push_frame(g2);
        i_en = 1'b1;
        @(posedge clk); #1;
        repeat (50) @(posedge clk);
        #1 apply_cfg(g2);
        repeat (418 - 1 - 50) @(posedge clk);
        #1 i_en = 1'b0;
        wait_idle("mid");
        chk("mid_len", busy_cnt, 418);
        chk("mid_de", de_cnt, 96);
        chk("mid_done", done_cnt, 2);

        clr_stats();
        apply_cfg(gz);
        push_frame(gz);
        run(105);
        wait_idle("zero");
        chk("zero_len", busy_cnt, 105);
        chk("zero_de", de_cnt, 0);
        chk("zero_hs", hs_cnt, 7);
        chk("zero_vs", vs_cnt, 15);

        clr_stats();
        apply_cfg(gs);
        push_frame(gs);
        run(165);
        wait_idle("solid");
        chk("solid_px", solid_cnt, 32);

        clr_stats();
        apply_cfg(gc);
        push_frame(gc);
        run(253);
        wait_idle("chk");
        chk("chk_len", busy_cnt, 253);
        chk("chk_de", de_cnt, 64);

        clr_stats();
        apply_cfg(g);
        push_frame(g);
        i_en = 1'b1;
        @(posedge clk); #1;
        repeat (70) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("rst_async", int'({o_vs, o_hs, o_de, o_busy, o_frame_done, o_r, o_g, o_b}), 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        clr_stats();
        push_frame(g);
        rstn = 1'b1;
        run(165);
        wait_idle("rst");
        chk("rst_len", busy_cnt, 165);
        chk("rst_first_de", first_de, 64);
        chk("rst_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
